dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port, word-addressed data memory between two requesters: port 0 (core load/store unit) and
//  port 1 (debug/DMA). Per-port valid/ready request handshake, round-robin grant, one transaction in flight.
//  Sequences the memory's 1-cycle registered read latency and returns per-port responses.
//  Rejects misaligned or out-of-range addresses without touching memory.
// PARAMETERS
//  ADDR_W     32   request/memory address width
//  DATA_W     32   data width
//  MEM_WORDS  256  memory depth in words; valid byte addresses are 0 .. 4*MEM_WORDS-1
// PORTS
//  clk             in   1       clock, all state on rising edge
//  rst             in   1       asynchronous reset, active-high
//  pN_req_valid    in   1       (N=0,1) request present; held with payload until accepted
//  pN_req_ready    out  1       request accepted this cycle (valid & ready = handshake)
//  pN_req_we       in   1       1 = write, 0 = read
//  pN_req_addr     in   ADDR_W  byte address
//  pN_req_wdata    in   DATA_W  write data
//  pN_rsp_valid    out  1       one-cycle response pulse; requester must take it (no backpressure)
//  pN_rsp_rdata    out  DATA_W  read data; 0 for writes and errors
//  pN_rsp_err      out  1       misaligned/out-of-range request; valid with pN_rsp_valid
//  mem_read        out  1       to memory MemRead
//  mem_write       out  1       to memory MemWrite
//  mem_address     out  ADDR_W  to memory address
//  mem_write_data  out  DATA_W  to memory write_data
//  mem_read_data   in   DATA_W  from memory read_data (registered in memory, valid the cycle after mem_read)
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=1 (port 0 wins first tie); all outputs 0; pending response discarded, no mem strobe.
//  FSM states IDLE, ISSUE, RESP:
//   IDLE : grant is combinational: one valid -> that port; both valid -> port != last_grant. Only the granted
//          port sees req_ready=1. On handshake, latch port id, we, addr, wdata; update last_grant.
//          Address legal -> ISSUE; illegal (addr[1:0]!=0 or addr >= 4*MEM_WORDS) -> RESP with err.
//   ISSUE: mem_read=~we, mem_write=we, mem_address/mem_write_data = latched values, all registered outputs,
//          asserted exactly this one cycle. -> RESP.
//   RESP : rsp_valid=1 on latched port only; rsp_rdata = mem_read_data for reads, 0 otherwise; rsp_err=latched err.
//          mem_read=mem_write=0. -> IDLE. req_ready=0 for both ports in ISSUE and RESP.
//  Latency: handshake in cycle T -> mem strobe T+1 -> response T+2 (legal); response T+1 (error).
//  Throughput: one transaction per 3 cycles (legal), 2 cycles (error). No overlap of transactions.
//  mem_address/mem_write_data hold last value outside ISSUE; only strobes return to 0.
//  Other port's requests stay pending (valid held); grant re-evaluated in next IDLE, so alternation is strict
//  under continuous contention.
//  Write to memory lands at end of ISSUE; a read of the same word accepted after it returns the new data.
//  Reset asserted in ISSUE or RESP: strobes/rsp_valid drop immediately (async), no response is ever issued.
//  Address compare is unsigned over full ADDR_W; no wrap-around of high address bits into memory.
// STRUCTURE
//  Shared package dmem_arb_pkg: state encoding (IDLE/ISSUE/RESP), port id constants P0/P1, addr-legal function.
//  One sub-module: rr_arbiter2 (2-way round-robin: req[1:0], accept, last_grant register -> one-hot grant).
//  Top holds FSM, request latch and response steering.
// TESTING
//  1 Reset: rst=1 mid-cycle -> all outputs 0 at once; after release p0 write idle bus -> ready only on p0.
//  2 p0 write addr 0x10 data 0xDEADBEEF, then p0 read 0x10 -> mem_write pulse T+1 addr 0x10;
//    read rsp_valid at T+2, rdata 0xDEADBEEF, err 0.
//  3 p0 and p1 both valid continuously, reads 0x0 / 0x4 -> grants alternate p0,p1,p0,p1;
//    each response on granting port only, 3 cycles apart.
//  4 p1 read addr 0x6 and p1 read 0x400 (MEM_WORDS=256) -> no mem strobe; rsp_valid at T+1, err=1, rdata=0.
//  5 rst asserted during ISSUE of p1 write 0x20 data 0x1234 -> no rsp_valid ever; after reset,
//    reading 0x20 returns the prior contents, not 0x1234 if reset preceded the strobe's edge.
//  6 Last word 0x3FC write 0xA5A5A5A5 then read -> rdata 0xA5A5A5A5, err 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding,
// port identifiers and the address legality check.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  // Word-aligned and below the byte limit; compared unsigned so high bits never wrap into memory.
  function automatic logic addr_legal(input logic [63:0] addr, input logic [63:0] limit_bytes);
    return (addr[1:0] == 2'b00) && (addr < limit_bytes);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin arbiter: one-hot grant from req, priority flips to the
// other port whenever a grant is accepted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant        = 2'b00;
    last_grant_d = last_grant_q;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (accept && (grant != 2'b00)) begin
      last_grant_d = grant[1];
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Reset to "port 1 last" so port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port word-addressed data memory between two requesters:
// round-robin grant, one transaction in flight, 1-cycle registered read latency.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  output logic              p0_rsp_err,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              p1_rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [63:0] LIMIT_BYTES = 64'(MEM_WORDS) * 64'd4;

  state_e              state_q, state_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_write_data_q, mem_write_data_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;

  logic [1:0]          req_s;
  logic [1:0]          grant_s;
  logic                accept_s;
  logic                sel_port_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic                sel_legal_s;
  logic                rd_ok_s;

  assign req_s = {p1_req_valid, p0_req_valid};

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req_s),
    .accept (accept_s),
    .grant  (grant_s)
  );

  // Ready is forced low while reset is asserted so every output reads 0 during reset.
  assign p0_req_ready = (state_q == ST_IDLE) && grant_s[0] && !rst;
  assign p1_req_ready = (state_q == ST_IDLE) && grant_s[1] && !rst;
  assign accept_s     = p0_req_ready || p1_req_ready;

  assign sel_port_s  = grant_s[1] ? P1 : P0;
  assign sel_we_s    = (sel_port_s == P1) ? p1_req_we    : p0_req_we;
  assign sel_addr_s  = (sel_port_s == P1) ? p1_req_addr  : p0_req_addr;
  assign sel_wdata_s = (sel_port_s == P1) ? p1_req_wdata : p0_req_wdata;
  assign sel_legal_s = addr_legal(64'(sel_addr_s), LIMIT_BYTES);

  always_comb begin
    state_d          = state_q;
    port_d           = port_q;
    we_d             = we_q;
    err_d            = err_q;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    rsp_valid_d      = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          port_d = sel_port_s;
          we_d   = sel_we_s;
          if (sel_legal_s) begin
            err_d            = 1'b0;
            mem_read_d       = !sel_we_s;
            mem_write_d      = sel_we_s;
            mem_address_d    = sel_addr_s;
            mem_write_data_d = sel_wdata_s;
            state_d          = ST_ISSUE;
          end else begin
            // Illegal requests skip memory entirely and answer next cycle.
            err_d       = 1'b1;
            rsp_valid_d = (sel_port_s == P1) ? 2'b10 : 2'b01;
            state_d     = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        rsp_valid_d = (port_q == P1) ? 2'b10 : 2'b01;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, request latch and registered memory/response strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      port_q           <= P0;
      we_q             <= 1'b0;
      err_q            <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      rsp_valid_q      <= 2'b00;
    end else begin
      state_q          <= state_d;
      port_q           <= port_d;
      we_q             <= we_d;
      err_q            <= err_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      rsp_valid_q      <= rsp_valid_d;
    end
  end

  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;

  // Memory data arrives in the response cycle, so read data is steered straight through.
  assign rd_ok_s      = !we_q && !err_q;
  assign p0_rsp_valid = rsp_valid_q[0];
  assign p1_rsp_valid = rsp_valid_q[1];
  assign p0_rsp_err   = rsp_valid_q[0] && err_q;
  assign p1_rsp_err   = rsp_valid_q[1] && err_q;
  assign p0_rsp_rdata = (rsp_valid_q[0] && rd_ok_s) ? mem_read_data : '0;
  assign p1_rsp_rdata = (rsp_valid_q[1] && rd_ok_s) ? mem_read_data : '0;

endmodule
